// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between a reset sequencer and its consumer
interface reset_sequencer_if #(
  parameter int STAGES = 4
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic              sw_rst_req;
  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] rst_out;
  logic              seq_done;
  logic              seq_fault;
  logic [IDX_W-1:0]  fault_stage;

  // Consumer side: requests restarts, reports per-stage readiness
  modport master (
    output sw_rst_req,
    output stage_ready,
    input  rst_out,
    input  seq_done,
    input  seq_fault,
    input  fault_stage
  );

  // Sequencer side
  modport slave (
    input  sw_rst_req,
    input  stage_ready,
    output rst_out,
    output seq_done,
    output seq_fault,
    output fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-stage reset release with gap, timeout and restart
module reset_sequencer #(
  parameter int STAGES         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // Terminal counts are "last value before the event edge"; zero-length cases clamp to 0
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STAGES - 1);
  localparam logic [STAGES-1:0] ONE      = {{(STAGES-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [STAGES-1:0] rst_out_q;
  logic              seq_done_q;
  logic              seq_fault_q;
  logic [IDX_W-1:0]  fault_stage_q;

  logic [IDX_W-1:0]  next_idx;
  logic [CNT_W-1:0]  cnt_inc;
  logic [STAGES-1:0] release_mask;
  logic              ready_now;

  assign next_idx     = idx + IDX_W'(1);
  assign cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign release_mask = ~(ONE << next_idx);
  assign ready_now    = bus.stage_ready[idx];

  // Sequencer FSM: hold, then release stages in ascending order gated by ready and gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_HOLD;
      cnt           <= '0;
      idx           <= '0;
      rst_out_q     <= '1;
      seq_done_q    <= 1'b0;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
    end else if (bus.sw_rst_req) begin
      state         <= S_HOLD;
      cnt           <= '0;
      idx           <= '0;
      rst_out_q     <= '1;
      seq_done_q    <= 1'b0;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out_q <= {{(STAGES-1){1'b1}}, 1'b0};
            cnt       <= '0;
            idx       <= '0;
            state     <= S_WAIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT: begin
          // Ready takes precedence over a timeout landing on the same edge
          if (ready_now) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state      <= S_DONE;
              seq_done_q <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              rst_out_q <= rst_out_q & release_mask;
              idx       <= next_idx;
            end else begin
              state <= S_GAP;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
            state         <= S_FAULT;
            seq_fault_q   <= 1'b1;
            fault_stage_q <= idx;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            rst_out_q <= rst_out_q & release_mask;
            idx       <= next_idx;
            cnt       <= '0;
            state     <= S_WAIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE, S_FAULT: begin
          // Terminal until rst or a software restart
        end
        default: begin
          state <= S_HOLD;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  assign bus.rst_out     = rst_out_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.seq_fault   = seq_fault_q;
  assign bus.fault_stage = fault_stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed vector bench for reset_sequencer
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.STAGES(3)) if_a ();
  reset_sequencer_if #(.STAGES(3)) if_b ();

  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));

  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    logic [2:0] ready;
    logic       sw;
    logic [2:0] exp_a;
    logic       done_a;
    logic [2:0] exp_b;
    logic       done_b;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] ra, input logic [2:0] rb, input logic sw);
    if_a.stage_ready = ra;
    if_b.stage_ready = rb;
    if_a.sw_rst_req  = sw;
    if_b.sw_rst_req  = sw;
    @(posedge clk);
    @(negedge clk);
    if_a.sw_rst_req  = 1'b0;
    if_b.sw_rst_req  = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ready, tbl[i].ready, tbl[i].sw);
      chk($sformatf("%s a rst_out e%0d", tag, i + 1), 32'(if_a.rst_out),  32'(tbl[i].exp_a));
      chk($sformatf("%s a seq_done e%0d", tag, i + 1), 32'(if_a.seq_done), 32'(tbl[i].done_a));
      chk($sformatf("%s b rst_out e%0d", tag, i + 1), 32'(if_b.rst_out),  32'(tbl[i].exp_b));
      chk($sformatf("%s b seq_done e%0d", tag, i + 1), 32'(if_b.seq_done), 32'(tbl[i].done_b));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e_rst;
    // edge-by-edge expectations with all stages ready: a has GAP=2, b has GAP=0
    tbl[0]  = '{3'b111, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[2]  = '{3'b111, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 3'b110, 1'b0, 3'b110, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 3'b110, 1'b0, 3'b100, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 3'b110, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1};
    tbl[7]  = '{3'b111, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1};
    tbl[9]  = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1};
    tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1};
    tbl[11] = '{3'b111, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1};

    if_a.sw_rst_req = 1'b0;  if_b.sw_rst_req = 1'b0;
    if_a.stage_ready = 3'b111; if_b.stage_ready = 3'b111;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset a rst_out",     32'(if_a.rst_out),     32'h7);
    chk("reset a seq_done",    32'(if_a.seq_done),    32'h0);
    chk("reset a seq_fault",   32'(if_a.seq_fault),   32'h0);
    chk("reset a fault_stage", 32'(if_a.fault_stage), 32'h0);
    chk("reset b rst_out",     32'(if_b.rst_out),     32'h7);
    rst = 1'b0;

    // Full sequence, all ready
    run_table("seq1");

    // Software restart from DONE repeats the same timing
    step(3'b111, 3'b111, 1'b1);
    chk("restart a rst_out",  32'(if_a.rst_out),  32'h7);
    chk("restart a seq_done", 32'(if_a.seq_done), 32'h0);
    chk("restart b seq_done", 32'(if_b.seq_done), 32'h0);
    run_table("seq2");

    // Stage 1 never ready: timeout
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step(3'b101, 3'b101, 1'b0);
      e_rst = (k < 4) ? 3'b111 : (k < 7) ? 3'b110 : 3'b100;
      chk($sformatf("to a rst_out e%0d", k),     32'(if_a.rst_out),     32'(e_rst));
      chk($sformatf("to a seq_fault e%0d", k),   32'(if_a.seq_fault),   32'(k >= 15));
      chk($sformatf("to a fault_stage e%0d", k), 32'(if_a.fault_stage), (k >= 15) ? 32'h1 : 32'h0);
      e_rst = (k < 4) ? 3'b111 : (k == 4) ? 3'b110 : 3'b100;
      chk($sformatf("to b rst_out e%0d", k),     32'(if_b.rst_out),     32'(e_rst));
      chk($sformatf("to b seq_fault e%0d", k),   32'(if_b.seq_fault),   32'(k >= 13));
    end
    chk("to a seq_done", 32'(if_a.seq_done), 32'h0);

    // Restart out of FAULT
    step(3'b111, 3'b111, 1'b1);
    chk("fault clr a rst_out",     32'(if_a.rst_out),     32'h7);
    chk("fault clr a seq_fault",   32'(if_a.seq_fault),   32'h0);
    chk("fault clr a fault_stage", 32'(if_a.fault_stage), 32'h0);
    chk("fault clr b seq_fault",   32'(if_b.seq_fault),   32'h0);
    run_table("seq3");

    // Ready arriving on the last allowed edge (a) vs never (b)
    step(3'b000, 3'b000, 1'b1);
    chk("late restart a rst_out", 32'(if_a.rst_out), 32'h7);
    for (int k = 1; k <= 13; k++) begin
      step((k >= 12) ? 3'b001 : 3'b000, 3'b000, 1'b0);
      chk($sformatf("late a seq_fault e%0d", k), 32'(if_a.seq_fault), 32'h0);
      chk($sformatf("late a rst_out e%0d", k),   32'(if_a.rst_out),   (k < 4) ? 32'h7 : 32'h6);
      chk($sformatf("late b seq_fault e%0d", k), 32'(if_b.seq_fault), 32'(k >= 12));
      chk($sformatf("late b rst_out e%0d", k),   32'(if_b.rst_out),   (k < 4) ? 32'h7 : 32'h6);
    end
    chk("late b fault_stage", 32'(if_b.fault_stage), 32'h0);

    // Async rst while a is in GAP: outputs reassert before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("async a rst_out",   32'(if_a.rst_out),   32'h7);
    chk("async b rst_out",   32'(if_b.rst_out),   32'h7);
    chk("async b seq_fault", 32'(if_b.seq_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_table("seq4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
